tribus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared tri-state bus driven by N bufif1-style drivers, one per requester.
- Grants bus ownership to at most one requester at a time and generates one-hot driver enables.
- Bounds each tenure to a maximum length and inserts an all-drivers-off turnaround gap between owners, so the bus never sees contention.
- Sits between requesting sources and the per-source tri-state enables of the shared net.

---
 rtl/tribus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_tribus_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tribus_arbiter.sv
// tribus_arbiter: round-robin owner selection and driver-enable sequencing
// for a shared tri-state net. At most one enable is ever high, tenures are
// capped at HOLD_MAX cycles, and TURNAROUND all-off cycles separate owners.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner, all enables off, waiting for any request
// OWN   | owner_id drives the bus; hold counter tracks tenure length
// GAP   | all enables off for TURNAROUND cycles before next arbitration
module tribus_arbiter #(
    parameter int N          = 4,
    parameter int IDW        = 2,
    parameter int HOLD_MAX   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   drv_en,
    output logic [IDW-1:0] owner_id,
    output logic           busy
);

    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int GW = $clog2(TURNAROUND + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] owner_id_q, owner_id_d;
    logic           busy_q, busy_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [IDW-1:0] win;

    function automatic logic bit_at(input logic [N-1:0] r, input logic [IDW-1:0] idx);
        logic [N-1:0] s;
        s = r >> idx;
        return s[0];
    endfunction

    // First set bit of r scanning upward from p, wrapping at N.
    function automatic logic [IDW-1:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] w;
        logic           found;
        logic [N-1:0]   s;
        int             idx;
        w     = '0;
        found = 1'b0;
        s     = '0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(p) + i;
            if (idx >= N) idx = idx - N;
            s = r >> idx;
            if (!found && s[0]) begin
                w     = IDW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] o);
        int n;
        n = int'(o) + 1;
        if (n >= N) n = 0;
        return IDW'(n);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IDW-1:0] o);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << o;
    endfunction

    // Winner from the current pointer, used on entry to OWN.
    always_comb begin
        win = pick(req, ptr_q);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        grant_d    = '0;
        owner_id_d = '0;
        busy_d     = 1'b0;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        gap_d      = gap_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = OWN;
                    hold_d     = '0;
                    owner_id_d = win;
                    grant_d    = onehot(win);
                    busy_d     = 1'b1;
                end
            end
            OWN: begin
                if (!bit_at(req, owner_id_q) || (hold_q == HW'(HOLD_MAX - 1))) begin
                    state_d = GAP;
                    ptr_d   = next_ptr(owner_id_q);
                    gap_d   = '0;
                end else begin
                    hold_d     = hold_q + 1'b1;
                    owner_id_d = owner_id_q;
                    grant_d    = onehot(owner_id_q);
                    busy_d     = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GW'(TURNAROUND - 1)) begin
                    if (|req) begin
                        state_d    = OWN;
                        hold_d     = '0;
                        owner_id_d = win;
                        grant_d    = onehot(win);
                        busy_d     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_id_q <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            hold_q     <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_id_q <= owner_id_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
        end
    end

    assign grant    = grant_q;
    assign drv_en   = grant_q;
    assign owner_id = owner_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Bench for tribus_arbiter: directed scenarios plus random requests, all
// compared against a tenure-level reference model and bus invariants.
module tb_tribus_arbiter;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int HOLD = 4;
    localparam int TURN = 1;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [N-1:0]   drv_en;
    logic [IDW-1:0] owner_id;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: current owner (-1 none), cycles held so far,
    // gap cycles remaining, round-robin start index.
    int m_owner = -1;
    int m_len   = 0;
    int m_gap   = 0;
    int m_ptr   = 0;

    logic [N-1:0] prev_en = '0;
    int           run_len = 0;

    tribus_arbiter #(
        .N(N), .IDW(IDW), .HOLD_MAX(HOLD), .TURNAROUND(TURN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
        .drv_en(drv_en), .owner_id(owner_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic arb(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            int k = (m_ptr + i) % N;
            if (m_owner < 0 && ((r >> k) & 1) != 0) begin
                m_owner = k;
                m_len   = 1;
            end
        end
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic rb);
        if (!rb) begin
            m_owner = -1; m_len = 0; m_gap = 0; m_ptr = 0;
        end else if (m_owner >= 0) begin
            if (((r >> m_owner) & 1) == 0 || m_len >= HOLD) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = TURN;
            end else begin
                m_len++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0 && r != 0) arb(r);
        end else if (r != 0) begin
            arb(r);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic rb);
        int exp_g;
        req   = r;
        rst_n = rb;
        @(posedge clk);
        model_edge(r, rb);
        #1;
        exp_g = (m_owner >= 0) ? (1 << m_owner) : 0;
        chk("grant",    grant,    exp_g);
        chk("drv_en",   drv_en,   exp_g);
        chk("owner_id", owner_id, (m_owner >= 0) ? m_owner : 0);
        chk("busy",     busy,     (m_owner >= 0) ? 1 : 0);
        chk("onehot_en", ($countones(drv_en) <= 1) ? 1 : 0, 1);
        chk("en_eq_grant", drv_en, grant);
        chk("turnaround", (prev_en != 0 && drv_en != 0 && drv_en != prev_en) ? 1 : 0, 0);
        if (drv_en != 0 && drv_en == prev_en) run_len++;
        else run_len = (drv_en != 0) ? 1 : 0;
        chk("tenure_len", (run_len <= HOLD) ? 1 : 0, 1);
        chk("id_idle", (!busy && owner_id != 0) ? 1 : 0, 0);
        prev_en = drv_en;
    endtask

    initial begin
        logic [N-1:0] rv;
        logic         rb;
        req   = '0;
        rst_n = 1'b0;

        // Reset held with every source requesting, then first grant.
        step(4'b1111, 1'b0);
        chk("t1_rst_grant", grant, 4'b0000);
        step(4'b1111, 1'b0);
        chk("t1_rst_busy", busy, 1'b0);
        step(4'b1111, 1'b1);
        chk("t1_first", grant, 4'b0001);

        // Short tenure released by dropping request.
        step(4'b0000, 1'b0);
        step(4'b0010, 1'b1);
        chk("t2_e0", grant, 4'b0010);
        chk("t2_id", owner_id, 1);
        step(4'b0010, 1'b1);
        chk("t2_e1", drv_en, 4'b0010);
        step(4'b0000, 1'b1);
        chk("t2_gap", grant, 4'b0000);
        step(4'b0000, 1'b1);
        chk("t2_idle", busy, 1'b0);

        // Lone continuous requester: timeout forces a gap each tenure.
        step(4'b0000, 1'b0);
        for (int k = 0; k < 15; k++) begin
            step(4'b0001, 1'b1);
            chk("t3_lone", grant, (k % 5 < 4) ? 1 : 0);
        end

        // All requesting: full rotation.
        step(4'b0000, 1'b0);
        for (int k = 0; k < 21; k++) begin
            step(4'b1111, 1'b1);
            chk("t4_rr", grant, (k % 5 < 4) ? (1 << ((k / 5) % 4)) : 0);
        end

        // Reset mid-tenure clears enables and the pointer.
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        chk("t5_own2", grant, 4'b0100);
        step(4'b0100, 1'b0);
        chk("t5_rst", drv_en, 4'b0000);
        step(4'b1100, 1'b1);
        chk("t5_after", grant, 4'b0100);

        // Random traffic with occasional resets.
        rv = '0;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 4) == 0) rv = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 199) != 0);
            step(rv, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
